// File: rtl/alu_mdu_if.sv
// alu_mdu_if: valid/ready operand and result bundle for the execute unit.
// master issues operations and consumes results; slave is the unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] opdA;
  logic [XLEN-1:0] opdB;
  logic [4:0]      op_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, opdA, opdB, op_sel,
    output out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, opdA, opdB, op_sel,
    input  out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU with iterative multiply/divide datapath.
// Define ALU_MDU_M_EN to build the RV32M ops; otherwise codes 16-23 are illegal.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic      clk,
  input logic      rst_n,
  alu_mdu_if.slave io
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      op;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] res_q;
  logic            ovalid_q;
  logic            take;

  assign a  = io.opdA;
  assign b  = io.opdB;
  assign op = io.op_sel;
  assign sh = b[SHW-1:0];

  assign take         = ovalid_q && io.out_ready;
  assign io.result    = res_q;
  assign io.out_valid = ovalid_q;

  always_comb begin
    base_res = '0;
    unique case (op)
      5'd0:    base_res = a + b;
      5'd1:    base_res = a - b;
      5'd2:    base_res = a ^ b;
      5'd3:    base_res = a | b;
      5'd4:    base_res = a & b;
      5'd5:    base_res = a >> sh;
      5'd6:    base_res = $signed(a) >>> sh;
      5'd7:    base_res = a << sh;
      5'd8:    base_res = {{(XLEN-1){1'b0}},
                           $signed(a) < $signed(b)};
      5'd9:    base_res = {{(XLEN-1){1'b0}}, a < b};
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MDU_M_EN
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     m;
  logic [2:0]          mop;
  logic                neg;

  logic                accept;
  logic                m_op;
  logic                is_mul;
  logic                is_rem;
  logic                sa;
  logic                sb;
  logic                dz;
  logic                ovf;
  logic                special;
  logic [XLEN-1:0]     ma;
  logic [XLEN-1:0]     mb;
  logic [XLEN-1:0]     spec_res;
  logic [XLEN-1:0]     imm_res;
  logic [XLEN:0]       madd;
  logic [XLEN:0]       rsh;
  logic [XLEN:0]       rsub;
  logic [2*XLEN-1:0]   acc_nxt;
  logic [2*XLEN-1:0]   pfix;
  logic [XLEN-1:0]     r;
  logic [XLEN-1:0]     fix_res;

  assign io.in_ready = (state == IDLE) &&
                       (!ovalid_q || io.out_ready);
  assign io.busy     = (state == ITER);
  assign accept      = io.in_valid && io.in_ready;

  assign m_op   = (op[4:3] == 2'b10);
  assign is_mul = !op[2];
  assign is_rem = op[1];

  // MULH/MULHSU treat A as signed, only MULH treats B as signed
  assign sa = a[XLEN-1] &&
              (is_mul ? (op[1] ^ op[0]) : !op[0]);
  assign sb = b[XLEN-1] &&
              (is_mul ? (op[1:0] == 2'b01) : !op[0]);
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  assign dz  = (b == '0);
  assign ovf = !op[0] && (b == '1) &&
               (a == {1'b1, {(XLEN-1){1'b0}}});
  assign special = m_op && !is_mul && (dz || ovf);

  assign spec_res = dz ? (is_rem ? a : '1)
                       : (is_rem ? '0 : a);
  assign imm_res  = special ? spec_res : base_res;

  // shift-add multiply: multiplier in low half, product grows from top
  assign madd = {1'b0, acc[2*XLEN-1:XLEN]} +
                (acc[0] ? {1'b0, m} : '0);
  // restoring divide: remainder in high half, quotient shifts into low
  assign rsh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign rsub = rsh - {1'b0, m};

  always_comb begin
    acc_nxt = acc;
    if (!mop[2])
      acc_nxt = {madd, acc[XLEN-1:1]};
    else if (rsub[XLEN])
      acc_nxt = {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_nxt = {rsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  assign pfix = neg ? -acc : acc;
  assign r    = mop[1] ? acc[2*XLEN-1:XLEN]
                       : acc[XLEN-1:0];

  always_comb begin
    fix_res = '0;
    if (!mop[2])
      fix_res = (mop[1:0] == 2'b00) ? pfix[XLEN-1:0]
                                    : pfix[2*XLEN-1:XLEN];
    else
      fix_res = neg ? -r : r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      mop      <= '0;
      neg      <= 1'b0;
      res_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      if (take)
        ovalid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (m_op && !special) begin
              state <= ITER;
              cnt   <= CW'(XLEN-1);
              mop   <= op[2:0];
              neg   <= (is_mul || !is_rem) ? (sa ^ sb) : sa;
              acc   <= {{XLEN{1'b0}}, is_mul ? mb : ma};
              m     <= is_mul ? ma : mb;
            end else begin
              res_q    <= imm_res;
              ovalid_q <= 1'b1;
            end
          end
        end
        ITER: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= DONE;
        end
        DONE: begin
          res_q    <= fix_res;
          ovalid_q <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign io.in_ready = !ovalid_q || io.out_ready;
  assign io.busy     = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      if (take)
        ovalid_q <= 1'b0;
      if (io.in_valid && io.in_ready) begin
        res_q    <= base_res;
        ovalid_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: vector table plus latency, backpressure and reset sequences.
// Results are scoreboarded; M-op expectations follow ALU_MDU_M_EN.
module tb_alu_mdu;

`ifdef ALU_MDU_M_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  logic [31:0] q[$];
  vec_t        tv[$];

  alu_mdu_if #(.XLEN(32)) bus ();

  alu_mdu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious: got %h, want none", bus.result);
      end else begin
        e = q.pop_front();
        check("result", bus.result, e);
      end
    end
  end

  function automatic void add(input logic [4:0] op,
                              input logic [31:0] a, b, e);
    vec_t v;
    v.op  = op;
    v.a   = a;
    v.b   = b;
    v.exp = e;
    tv.push_back(v);
  endfunction

  function automatic void addm(input logic [4:0] op,
                               input logic [31:0] a, b, e);
    add(op, a, b, MEN ? e : 32'h0);
  endfunction

  task automatic issue(input logic [4:0] op,
                       input logic [31:0] a, b, e);
    int n = 0;
    bus.op_sel   = op;
    bus.opdA     = a;
    bus.opdB     = b;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: in_ready=0, want 1");
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", q.size(), 0);
  endtask

  task automatic lat(input logic [4:0] op,
                     input logic [31:0] a, b, e,
                     input int el, input int eb);
    int n  = 1;
    int nb = 0;
    int ni = 0;
    drain();
    bus.op_sel   = op;
    bus.opdA     = a;
    bus.opdB     = b;
    bus.in_valid = 1'b1;
    check("lat_in_ready", bus.in_ready, 1);
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.opdA     = $urandom;
    bus.opdB     = $urandom;
    bus.op_sel   = 5'(op + 1);
    while (!bus.out_valid && n < 100) begin
      if (bus.busy) nb++;
      if (bus.in_ready) ni++;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, el);
    check("busy_cycles", nb, eb);
    check("in_ready_iter", ni, 0);
  endtask

  initial begin
    int t0;
    bus.in_valid  = 1'b0;
    bus.opdA      = '0;
    bus.opdB      = '0;
    bus.op_sel    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);

    lat(5'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 0);
    lat(5'd6, 32'h80000000, 32'h24, 32'hF8000000, 1, 0);
    lat(5'd17, 32'h80000000, 32'h80000000,
        MEN ? 32'h40000000 : 32'h0, MEN ? 33 : 1, MEN ? 32 : 0);
    lat(5'd18, 32'hFFFFFFFF, 32'd2,
        MEN ? 32'hFFFFFFFF : 32'h0, MEN ? 33 : 1, MEN ? 32 : 0);
    lat(5'd20, 32'd7, 32'd0,
        MEN ? 32'hFFFFFFFF : 32'h0, 1, 0);
    lat(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);
    lat(5'd21, 32'd100, 32'd7,
        MEN ? 32'd14 : 32'h0, MEN ? 33 : 1, MEN ? 32 : 0);
    lat(5'd31, 32'd1234, 32'd5678, 32'h0, 1, 0);
    drain();

    t0 = cyc;
    issue(5'd0, 32'hFFFFFFFF, 32'd1, 32'h0);
    issue(5'd8, 32'hFFFFFFFF, 32'd1, 32'd1);
    issue(5'd9, 32'hFFFFFFFF, 32'd1, 32'd0);
    check("b2b_cycles", cyc - t0, 3);
    drain();

    bus.out_ready = 1'b0;
    issue(5'd0, 32'd2, 32'd3, 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("hold_result", bus.result, 32'd5);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.op_sel    = 5'd2;
    bus.opdA      = 32'hF0F0F0F0;
    bus.opdB      = 32'hFFFFFFFF;
    bus.in_valid  = 1'b1;
    #1;
    check("xfer_in_ready", bus.in_ready, 1);
    q.push_back(32'h0F0F0F0F);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("xfer_valid", bus.out_valid, 1);
    check("xfer_result", bus.result, 32'h0F0F0F0F);
    drain();

    if (!MEN) q.push_back(32'h0);
    bus.op_sel   = 5'd21;
    bus.opdA     = 32'd100;
    bus.opdB     = 32'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", bus.busy, MEN);
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_result", bus.result, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_partial", bus.out_valid, 0);
    issue(5'd0, 32'd1, 32'd1, 32'd2);
    drain();

    add(5'd2, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F);
    add(5'd3, 32'h00000F00, 32'h000000F0, 32'h00000FF0);
    add(5'd4, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
    add(5'd5, 32'h80000000, 32'd31, 32'h00000001);
    add(5'd7, 32'h00000001, 32'h21, 32'h00000002);
    add(5'd6, 32'h7FFFFFFF, 32'd4, 32'h07FFFFFF);
    add(5'd8, 32'd1, 32'hFFFFFFFF, 32'd0);
    add(5'd9, 32'd1, 32'hFFFFFFFF, 32'd1);
    add(5'd10, 32'd3, 32'd4, 32'd0);
    add(5'd31, 32'd3, 32'd4, 32'd0);
    addm(5'd16, 32'd7, 32'd6, 32'd42);
    addm(5'd16, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
    addm(5'd17, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
    addm(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    addm(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    addm(5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    addm(5'd22, 32'd7, 32'hFFFFFFFE, 32'd1);
    addm(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    addm(5'd23, 32'd9, 32'd0, 32'd9);
    addm(5'd23, 32'd100, 32'd7, 32'd2);
    addm(5'd21, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);

    foreach (tv[i])
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].exp);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked execution unit that replaces the purely combinational ALU in the core's execute stage. Single-cycle integer ops return one cycle after acceptance. RV32M-style multiply/divide ops run on a shared iterative shift-add / restoring-divide datapath. The unit uses a valid/ready handshake on both sides so the pipeline can stall on long operations.

## Interface

Parameters:
- `XLEN`, default 32: operand/result width; must be a power of two and ≥ 8.
- `SHW`, default `$clog2(XLEN)`: number of low bits of `opdB` used as the shift amount.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: an operation is offered.
- `in_ready`, out, 1: the unit accepts the offered operation this cycle.
- `opdA`, in, XLEN: operand A (rs1).
- `opdB`, in, XLEN: operand B (rs2/imm).
- `op_sel`, in, 5: operation code.
- `out_valid`, out, 1: `result` is valid.
- `out_ready`, in, 1: the consumer takes `result` this cycle.
- `result`, out, XLEN: registered result.
- `busy`, out, 1: an iterative operation is in progress.

## Operation

- Accept on `in_valid && in_ready`. Transfer out on `out_valid && out_ready`.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
- `op_sel` encoding, base ops:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 SRL, 6 SRA, 7 SLL, all shifting by `opdB[SHW-1:0]`.
  - 8 SLT (signed), 9 SLTU; result is zero-extended 0/1.
- `op_sel` encoding, M ops:
  - 16 MUL (low XLEN bits), 17 MULH (s×s), 18 MULHSU (s×u), 19 MULHU (u×u); MULH* return the high XLEN bits.
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Any other code is illegal: `result` = 0 with single-cycle timing. Illegal codes never hang the unit.
- States:
  - IDLE: base, illegal and special-case ops go straight to the output register.
  - ITER: one bit per cycle, counter runs XLEN-1 down to 0.
  - DONE: sign fix-up, then the result is loaded into the output register. Returns to IDLE.
- Signed M ops use magnitudes internally. The final negation is applied in DONE. The product is 2·XLEN wide.
- Division special cases are resolved in IDLE with base-op timing:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = `opdA`.
  - Signed overflow (A = −2^(XLEN−1), B = −1): DIV = A; REM = 0.
- Arithmetic wraps modulo 2^XLEN. No flags.
- `result` holds its value until the next load. It is not cleared on transfer.

## Timing

- Reset values: `out_valid`=0, `result`=0, `busy`=0, state=IDLE. `in_ready` follows combinationally and reads 1 after reset.
- Base, illegal and special-case ops: accepted at edge k, `out_valid`=1 after edge k. Back-to-back throughput is 1 per cycle when `out_ready`=1.
- Iterative ops: accepted at edge k. `busy`=1 from after edge k through after edge k+XLEN−1. `out_valid`=1 after edge k+XLEN+1 (latency XLEN+1).
- `in_ready`=0 throughout ITER and DONE.
- When `out_valid`=1 and `out_ready`=0, `result` and `out_valid` are held. `in_ready`=0 until the result is taken.
- When a transfer and a new acceptance happen in the same cycle, the new result overwrites the old one. No bubble is inserted.
- Operands and `op_sel` are latched on acceptance. Input changes during ITER are ignored.
- Asserting `rst_n` mid-ITER aborts immediately to the reset values. No partial result is ever presented.

## Configuration

- `ALU_MDU_M_EN` defined: M ops implemented as described above.
- `ALU_MDU_M_EN` undefined:
  - Codes 16–23 are illegal: `result`=0 with single-cycle timing.
  - ITER/DONE states, counter and multiply/divide datapath are not synthesised.
  - `busy` is tied to 0.

## Test plan

- Reset, then SUB with A=5, B=7 and `out_ready`=1: `out_valid` after one edge, `result`=0xFFFFFFFE. SRA with A=0x80000000, B=0x24: shifts by 4, `result`=0xF8000000.
- Back-to-back ADD, SLT, SLTU with A=0xFFFFFFFF, B=1: one result per cycle, in order 0x00000000, 1, 0.
- MULH with A=0x80000000, B=0x80000000: `busy` for 32 cycles, `out_valid` 33 cycles after acceptance, `result`=0x40000000. MULHSU with A=−1, B=2: `result`=0xFFFFFFFF.
- DIV with A=7, B=0: `result`=0xFFFFFFFF after one cycle. REM with A=0x80000000, B=−1: `result`=0. DIVU with A=100, B=7: `result`=14 at latency 33.
- Hold `out_ready`=0 after a result: `result` stable, `in_ready`=0. Then raise `out_ready` together with `in_valid` (XOR 0xF0F0F0F0, 0xFFFFFFFF): transfer and accept in the same cycle, next `result`=0x0F0F0F0F.
- Drop `rst_n` mid-DIVU: all outputs reset asynchronously, and the next ADD 1+1 returns 2. Illegal code 31: `result`=0, no hang.
